// File: rtl/pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// pipe_cla_adder
//
// Pipelined carry-lookahead adder. The NBIT-wide operands are split into NSEG
// segments of W = NBIT/NSEG bits. Stage k adds segment k with a lookahead
// carry network, seeded by the carry registered in stage k-1 (cin for
// stage 0). Operands travel down the pipe with their operation so each stage
// can find its segment. Finished lower sum segments travel alongside, so the
// whole sum leaves the last stage in one cycle.
//
// A single advance enable (en = out_ready | ~out_valid) moves every stage
// together. Empty slots flow through as bubbles. A result that is stalled at
// the output stays stable.
//
// Optional feature: define ADDER_OVF_EN to add the 'ovf' output. This is
// two's-complement signed overflow, aligned with 's'.
//
// Parameters
//   NBIT  operand / sum width (default 32)
//   NSEG  carry segments = pipeline stages (default 4); NBIT % NSEG == 0
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   a, b, cin  operands and carry-in
//   in_valid   operand set valid
//   in_ready   block accepts an operand set this cycle
//   s, cout    sum and carry-out of bit NBIT-1
//   ovf        signed overflow (only with ADDER_OVF_EN)
//   out_valid  s / cout valid
//   out_ready  downstream accepts the result
// ---------------------------------------------------------------------------
module pipe_cla_adder #(
   parameter int NBIT = 32,
   parameter int NSEG = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NBIT-1:0] a,
   input  logic [NBIT-1:0] b,
   input  logic            cin,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [NBIT-1:0] s,
   output logic            cout,
`ifdef ADDER_OVF_EN
   output logic            ovf,
`endif
   output logic            out_valid,
   input  logic            out_ready
);

   localparam int W = NBIT / NSEG;

   // Stage registers: index k is the output of stage k.
   logic [NBIT-1:0] a_q [NSEG];
   logic [NBIT-1:0] b_q [NSEG];
   logic [NBIT-1:0] s_q [NSEG];
   logic [NSEG-1:0] c_q;
   logic [NSEG-1:0] v_q;

   // Stage inputs (what stage k sees) and next-state values.
   logic [NBIT-1:0] a_src [NSEG];
   logic [NBIT-1:0] b_src [NSEG];
   logic [NBIT-1:0] s_src [NSEG];
   logic [NBIT-1:0] s_nx  [NSEG];
   logic [NSEG-1:0] c_src;
   logic [NSEG-1:0] v_src;
   logic [NSEG-1:0] c_nx;

   // Lookahead scratch, reused for every stage inside the combinational loop.
   logic [W-1:0]    g;
   logic [W-1:0]    p;
   logic [W:0]      cc;     // cc[i] = carry into bit i of the segment
   logic            grp_g;  // group generate of bits [i:0]
   logic            grp_p;  // group propagate of bits [i:0]

`ifdef ADDER_OVF_EN
   logic            ovf_nx;
   logic            ovf_q;
`endif

   logic            en;

   assign out_valid = v_q[NSEG-1];
   assign s         = s_q[NSEG-1];
   assign cout      = c_q[NSEG-1];
   assign en        = out_ready | ~out_valid;
   assign in_ready  = en;

   // Stage 0 takes the ports. Every later stage takes its predecessor's registers.
   always_comb begin : src_sel
      // NOTE: every combinational output gets a default before any
      // conditional or looped assignment, so no latch can be inferred.
      c_src    = '0;
      v_src    = '0;
      a_src[0] = a;
      b_src[0] = b;
      s_src[0] = '0;
      c_src[0] = cin;
      v_src[0] = in_valid;
      for (int k = 1; k < NSEG; k++) begin
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         s_src[k] = s_q[k-1];
         c_src[k] = c_q[k-1];
         v_src[k] = v_q[k-1];
      end
   end

   // Per-segment carry lookahead. Each carry is written as the group
   // generate, or the group propagate ANDed with the segment carry-in:
   // c[i+1] = G[i:0] | (P[i:0] & c_in).
   always_comb begin : cla
      g     = '0;
      p     = '0;
      cc    = '0;
      grp_g = 1'b0;
      grp_p = 1'b1;
      c_nx  = '0;
`ifdef ADDER_OVF_EN
      ovf_nx = 1'b0;
`endif
      for (int k = 0; k < NSEG; k++) begin
         g     = a_src[k][k*W +: W] & b_src[k][k*W +: W];
         p     = a_src[k][k*W +: W] ^ b_src[k][k*W +: W];
         cc[0] = c_src[k];
         grp_g = 1'b0;
         grp_p = 1'b1;
         for (int i = 0; i < W; i++) begin
            grp_g   = g[i] | (p[i] & grp_g);
            grp_p   = grp_p & p[i];
            cc[i+1] = grp_g | (grp_p & c_src[k]);
         end
         s_nx[k]             = s_src[k];
         s_nx[k][k*W +: W]   = p ^ cc[W-1:0];
         c_nx[k]             = cc[W];
`ifdef ADDER_OVF_EN
         // Signed overflow is the carry into the MSB XOR the carry out of it.
         if (k == NSEG-1) ovf_nx = cc[W-1] ^ cc[W];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the stage arrays are plain pipeline registers, not a RAM.
         // Clearing them on reset is what makes s = 0 while in reset.
         for (int k = 0; k < NSEG; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q <= '0;
         v_q <= '0;
      end else if (en) begin
         // NOTE: sequential state uses non-blocking assignments, so all
         // stages sample their predecessor's old value on the same edge.
         for (int k = 0; k < NSEG; k++) begin
            a_q[k] <= a_src[k];
            b_q[k] <= b_src[k];
            s_q[k] <= s_nx[k];
         end
         c_q <= c_nx;
         v_q <= v_src;
      end
   end

`ifdef ADDER_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_nx;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
